guess_controller: RTL and testbench

- Game-control FSM for the guess-number design.
- Collects a 4-digit guess from debounced keypad events, checks digit validity, and compares the guess against the answer on ENTER (A/B scoring).
- Drives the status triple consumed by the dot-matrix stage: reachS5, inCorrect, ansCorrect.
- Runs on the same divided clock as the display stage.

---
 rtl/guess_controller_if.sv | 26 ++
 rtl/guess_controller.sv | 212 +++++++++++++++++++++
 tb/tb_guess_controller.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/guess_controller_if.sv
// Keypad/answer inputs and status outputs shared between the guess-number
// controller and whatever drives it.
interface guess_controller_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        clear;
    logic [15:0] answer;
    logic [15:0] guess;
    logic        reachS5;
    logic        inCorrect;
    logic        ansCorrect;
    logic [2:0]  a_count;
    logic [2:0]  b_count;
    logic [3:0]  tries;
    logic        game_over;

    modport master (
        output key_valid, key_code, clear, answer,
        input  guess, reachS5, inCorrect, ansCorrect, a_count, b_count, tries, game_over
    );

    modport slave (
        input  key_valid, key_code, clear, answer,
        output guess, reachS5, inCorrect, ansCorrect, a_count, b_count, tries, game_over
    );
endinterface

// File: rtl/guess_controller.sv
// Game-control FSM for the guess-number design: collects four keypad digits,
// flags duplicates, and scores the guess against the answer on ENTER (A/B).
module guess_controller #(
    parameter int MAX_TRIES = 10
) (
    input  logic               clk_div,
    input  logic               rst,
    guess_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } state_t;

    localparam logic [3:0] MAX_T     = 4'(MAX_TRIES);
    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_BACK  = 4'hB;

    state_t      state_r;
    logic [15:0] guess_r;
    logic        in_correct_r;
    logic        ans_correct_r;
    logic        reach_s5_r;
    logic [2:0]  a_count_r;
    logic [2:0]  b_count_r;
    logic [3:0]  tries_r;
    logic        game_over_r;

    logic [2:0]  held_s;
    logic [2:0]  del_idx_s;
    logic [15:0] ins_mask_s;
    logic [15:0] del_mask_s;
    logic [15:0] guess_ins_s;
    logic [15:0] guess_del_s;
    logic        valid_ins_s;
    logic        valid_del_s;
    logic        is_digit_s;
    logic        is_known_s;
    logic        is_match_s;
    logic [2:0]  a_s;
    logic [2:0]  b_s;
    logic [3:0]  tries_inc_s;

    // Nibble index 0 is the first-entered digit, held in [15:12].
    function automatic logic [15:0] nib_mask(input logic [2:0] idx);
        logic [15:0] m;
        case (idx)
            3'd0:    m = 16'hF000;
            3'd1:    m = 16'h0F00;
            3'd2:    m = 16'h00F0;
            3'd3:    m = 16'h000F;
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

    // True when the first n held digits are pairwise distinct.
    function automatic logic digits_distinct(input logic [15:0] g, input logic [2:0] n);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (i < j && j < int'(n) && g[15-4*i -: 4] == g[15-4*j -: 4]) begin
                    ok = 1'b0;
                end else begin
                    ok = ok;
                end
            end
        end
        return ok;
    endfunction

    function automatic logic [2:0] a_score(input logic [15:0] g, input logic [15:0] a);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[4*i +: 4] == a[4*i +: 4]) begin
                cnt = cnt + 3'd1;
            end else begin
                cnt = cnt;
            end
        end
        return cnt;
    endfunction

    // A guess digit scores B once if it occurs at any other answer position.
    function automatic logic [2:0] b_score(input logic [15:0] g, input logic [15:0] a);
        logic [2:0] cnt;
        logic       hit;
        cnt = 3'd0;
        for (int i = 0; i < 4; i++) begin
            hit = 1'b0;
            for (int j = 0; j < 4; j++) begin
                if (i != j && g[4*i +: 4] == a[4*j +: 4]) begin
                    hit = 1'b1;
                end else begin
                    hit = hit;
                end
            end
            if (hit) begin
                cnt = cnt + 3'd1;
            end else begin
                cnt = cnt;
            end
        end
        return cnt;
    endfunction

    // Candidate next-guess values for digit insert, backspace and evaluation.
    always_comb begin
        held_s      = state_r;
        del_idx_s   = held_s - 3'd1;
        ins_mask_s  = nib_mask(held_s);
        del_mask_s  = nib_mask(del_idx_s);
        guess_ins_s = (guess_r & ~ins_mask_s) | ({4{bus.key_code}} & ins_mask_s);
        guess_del_s = guess_r & ~del_mask_s;
        valid_ins_s = digits_distinct(guess_ins_s, held_s + 3'd1);
        valid_del_s = digits_distinct(guess_del_s, del_idx_s);
        is_digit_s  = (bus.key_code <= 4'd9);
        is_known_s  = (bus.key_code <= KEY_BACK);
        is_match_s  = (guess_r == bus.answer);
        a_s         = a_score(guess_r, bus.answer);
        b_s         = b_score(guess_r, bus.answer);
        if (tries_r >= MAX_T) begin
            tries_inc_s = MAX_T;
        end else begin
            tries_inc_s = tries_r + 4'd1;
        end
    end

    // Game FSM with all status outputs registered.
    always_ff @(posedge clk_div or negedge rst) begin
        if (!rst) begin
            state_r       <= S0;
            guess_r       <= 16'h0000;
            in_correct_r  <= 1'b1;
            ans_correct_r <= 1'b0;
            reach_s5_r    <= 1'b0;
            a_count_r     <= 3'd0;
            b_count_r     <= 3'd0;
            tries_r       <= 4'd0;
            game_over_r   <= 1'b0;
        end else if (bus.clear) begin
            state_r       <= S0;
            guess_r       <= 16'h0000;
            in_correct_r  <= 1'b1;
            ans_correct_r <= 1'b0;
            reach_s5_r    <= 1'b0;
            a_count_r     <= 3'd0;
            b_count_r     <= 3'd0;
            tries_r       <= 4'd0;
            game_over_r   <= 1'b0;
        end else if (bus.key_valid && is_known_s && !game_over_r) begin
            case (state_r)
                S0, S1, S2, S3: begin
                    if (is_digit_s) begin
                        state_r      <= state_t'(held_s + 3'd1);
                        guess_r      <= guess_ins_s;
                        in_correct_r <= valid_ins_s;
                    end else if (bus.key_code == KEY_BACK && state_r != S0) begin
                        state_r      <= state_t'(del_idx_s);
                        guess_r      <= guess_del_s;
                        in_correct_r <= valid_del_s;
                    end
                end
                S4: begin
                    if (bus.key_code == KEY_BACK) begin
                        state_r      <= S3;
                        guess_r      <= guess_del_s;
                        in_correct_r <= valid_del_s;
                    end else if (bus.key_code == KEY_ENTER && in_correct_r) begin
                        state_r       <= S5;
                        reach_s5_r    <= 1'b1;
                        ans_correct_r <= is_match_s;
                        a_count_r     <= a_s;
                        b_count_r     <= b_s;
                        tries_r       <= tries_inc_s;
                        game_over_r   <= is_match_s || (tries_inc_s == MAX_T);
                    end
                end
                S5: begin
                    // Result acknowledged: start a new entry, keep the try count.
                    state_r       <= S0;
                    guess_r       <= 16'h0000;
                    in_correct_r  <= 1'b1;
                    ans_correct_r <= 1'b0;
                    reach_s5_r    <= 1'b0;
                    a_count_r     <= 3'd0;
                    b_count_r     <= 3'd0;
                end
                default: begin
                    state_r <= S0;
                end
            endcase
        end
    end

    assign bus.guess      = guess_r;
    assign bus.reachS5    = reach_s5_r;
    assign bus.inCorrect  = in_correct_r;
    assign bus.ansCorrect = ans_correct_r;
    assign bus.a_count    = a_count_r;
    assign bus.b_count    = b_count_r;
    assign bus.tries      = tries_r;
    assign bus.game_over  = game_over_r;

endmodule

// File: tb/tb_guess_controller.sv
// Scoreboard bench for guess_controller: a behavioural game model queues the
// expected status word per stimulus cycle, compared one edge later.
module tb_guess_controller;

    localparam int MAX_TRIES = 2;
    localparam logic [29:0] RESET_VEC = {16'h0000, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 4'd0, 1'b0};

    logic clk_div;
    logic rst;
    guess_controller_if bus ();

    guess_controller #(.MAX_TRIES(MAX_TRIES)) dut (
        .clk_div (clk_div),
        .rst     (rst),
        .bus     (bus)
    );

    initial clk_div = 1'b0;
    always #5 clk_div = ~clk_div;

    int errors = 0;
    int checks = 0;
    logic [29:0] exp_q[$];

    // Reference game model, kept as a digit list rather than packed nibbles.
    int m_n;
    int m_d[4];
    bit m_s5, m_inc, m_ans, m_go;
    int m_a, m_b, m_t;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_s5 = 0; m_inc = 1; m_ans = 0; m_go = 0; m_a = 0; m_b = 0; m_t = 0;
    endtask

    function automatic bit model_distinct();
        for (int i = 0; i < m_n; i++)
            for (int j = i + 1; j < m_n; j++)
                if (m_d[i] == m_d[j]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_eval(input logic [15:0] answer);
        int ad[4];
        for (int j = 0; j < 4; j++) ad[j] = int'((answer >> (12 - 4*j)) & 16'h000F);
        m_a = 0; m_b = 0;
        for (int i = 0; i < 4; i++) begin
            bit hit = 0;
            if (m_d[i] == ad[i]) m_a++;
            for (int j = 0; j < 4; j++) if (j != i && m_d[i] == ad[j]) hit = 1;
            if (hit) m_b++;
        end
        m_ans = (m_a == 4);
        m_t   = (m_t + 1 > MAX_TRIES) ? MAX_TRIES : m_t + 1;
        m_go  = m_ans || (m_t == MAX_TRIES);
        m_s5  = 1;
    endtask

    task automatic model_step(input bit v, input int c, input bit clr, input logic [15:0] answer);
        if (clr) model_reset();
        else if (v && !m_go && c <= 11) begin
            if (m_s5) begin
                m_s5 = 0; m_n = 0; m_inc = 1; m_ans = 0; m_a = 0; m_b = 0;
            end else if (c <= 9) begin
                if (m_n < 4) begin m_d[m_n] = c; m_n++; m_inc = model_distinct(); end
            end else if (c == 11) begin
                if (m_n > 0) begin m_n--; m_inc = model_distinct(); end
            end else if (m_n == 4 && m_inc) begin
                model_eval(answer);
            end
        end
    endtask

    function automatic logic [29:0] model_vec();
        logic [15:0] g = 16'h0000;
        for (int i = 0; i < m_n; i++) g = g | 16'(m_d[i] << (12 - 4*i));
        return {g, m_s5, m_inc, m_ans, 3'(m_a), 3'(m_b), 4'(m_t), m_go};
    endfunction

    function automatic logic [29:0] observed();
        return {bus.guess, bus.reachS5, bus.inCorrect, bus.ansCorrect,
                bus.a_count, bus.b_count, bus.tries, bus.game_over};
    endfunction

    task automatic cycle(input bit v, input logic [3:0] c, input bit clr);
        logic [29:0] expv;
        @(negedge clk_div);
        bus.key_valid = v;
        bus.key_code  = c;
        bus.clear     = clr;
        model_step(v, int'(c), clr, bus.answer);
        exp_q.push_back(model_vec());
        @(posedge clk_div);
        #1;
        bus.key_valid = 1'b0;
        bus.clear     = 1'b0;
        expv = exp_q.pop_front();
        check_eq($sformatf("step v=%0d k=%0h clr=%0d", v, c, clr), 32'(observed()), 32'(expv));
    endtask

    task automatic keys(input logic [3:0] k0, input logic [3:0] k1, input logic [3:0] k2, input logic [3:0] k3);
        cycle(1'b1, k0, 1'b0);
        cycle(1'b1, k1, 1'b0);
        cycle(1'b1, k2, 1'b0);
        cycle(1'b1, k3, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        bus.clear     = 1'b0;
        bus.answer    = 16'h1234;
        model_reset();
        #12;
        check_eq("reset_state", 32'(observed()), 32'(RESET_VEC));
        @(negedge clk_div);
        rst = 1'b1;

        // Correct guess solves the game; further keys are ignored.
        keys(4'h1, 4'h2, 4'h3, 4'h4);
        cycle(1'b1, 4'hA, 1'b0);
        check_eq("t1_solved", 32'(observed()), 32'({16'h1234, 1'b1, 1'b1, 1'b1, 3'd4, 3'd0, 4'd1, 1'b1}));
        cycle(1'b1, 4'h5, 1'b0);
        check_eq("t1_hold_guess", 32'(bus.guess), 32'h1234);
        cycle(1'b0, 4'h0, 1'b1);

        // Fully permuted guess: B=4, any key then returns to S0 keeping tries.
        keys(4'h4, 4'h3, 4'h2, 4'h1);
        cycle(1'b1, 4'hA, 1'b0);
        check_eq("t2_perm", 32'(observed()), 32'({16'h4321, 1'b1, 1'b1, 1'b0, 3'd0, 3'd4, 4'd1, 1'b0}));
        cycle(1'b1, 4'h0, 1'b0);
        check_eq("t2_back_s0", 32'(observed()), 32'({16'h0000, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 4'd1, 1'b0}));

        // Duplicate detection, blocked ENTER, backspace repair; second try ends the game.
        cycle(1'b1, 4'h5, 1'b0);
        cycle(1'b1, 4'h5, 1'b0);
        check_eq("t3_dup", 32'(bus.inCorrect), 32'd0);
        cycle(1'b1, 4'h6, 1'b0);
        cycle(1'b1, 4'h7, 1'b0);
        cycle(1'b1, 4'hA, 1'b0);
        check_eq("t3_enter_blocked", 32'(bus.reachS5), 32'd0);
        cycle(1'b1, 4'hB, 1'b0);
        cycle(1'b1, 4'hB, 1'b0);
        cycle(1'b1, 4'hB, 1'b0);
        cycle(1'b1, 4'h6, 1'b0);
        cycle(1'b1, 4'h7, 1'b0);
        cycle(1'b1, 4'h8, 1'b0);
        check_eq("t3_repaired", 32'({bus.guess, bus.inCorrect}), 32'({16'h5678, 1'b1}));
        cycle(1'b1, 4'hA, 1'b0);
        check_eq("t3_result", 32'({bus.reachS5, bus.tries, bus.game_over}), 32'({1'b1, 4'd2, 1'b1}));
        cycle(1'b1, 4'h1, 1'b0);
        cycle(1'b0, 4'h0, 1'b1);

        // Two wrong guesses exhaust MAX_TRIES; clear restores reset values.
        keys(4'h5, 4'h6, 4'h7, 4'h8);
        cycle(1'b1, 4'hA, 1'b0);
        check_eq("t4_first", 32'({bus.tries, bus.game_over}), 32'({4'd1, 1'b0}));
        cycle(1'b1, 4'h9, 1'b0);
        keys(4'h5, 4'h6, 4'h7, 4'h8);
        cycle(1'b1, 4'hA, 1'b0);
        check_eq("t4_second", 32'({bus.tries, bus.game_over, bus.ansCorrect}), 32'({4'd2, 1'b1, 1'b0}));
        cycle(1'b1, 4'h0, 1'b0);
        cycle(1'b1, 4'hB, 1'b0);
        cycle(1'b0, 4'h0, 1'b1);
        check_eq("t4_clear", 32'(observed()), 32'(RESET_VEC));

        // Asynchronous reset mid-entry, then clear beats a same-cycle key.
        cycle(1'b1, 4'h1, 1'b0);
        cycle(1'b1, 4'h2, 1'b0);
        cycle(1'b1, 4'h3, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_eq("t5_async_rst", 32'(observed()), 32'(RESET_VEC));
        model_reset();
        @(negedge clk_div);
        rst = 1'b1;
        cycle(1'b1, 4'h7, 1'b1);
        check_eq("t5_clear_wins", 32'(bus.guess), 32'h0000);

        // Undefined codes and BACKSPACE in S0, undefined codes in S4 and S5.
        bus.answer = 16'h5678;
        cycle(1'b1, 4'hC, 1'b0);
        cycle(1'b1, 4'hF, 1'b0);
        cycle(1'b1, 4'hB, 1'b0);
        keys(4'h1, 4'h2, 4'h3, 4'h4);
        cycle(1'b1, 4'hC, 1'b0);
        cycle(1'b1, 4'hF, 1'b0);
        cycle(1'b1, 4'hD, 1'b0);
        cycle(1'b1, 4'hA, 1'b0);
        cycle(1'b1, 4'hC, 1'b0);
        cycle(1'b1, 4'hF, 1'b0);
        cycle(1'b1, 4'hE, 1'b0);
        check_eq("t6_s5_hold", 32'(observed()), 32'({16'h1234, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 4'd1, 1'b0}));

        // Random key traffic against the model.
        bus.answer = 16'h3907;
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), ($urandom_range(0, 29) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
